race_sequencer: RTL and testbench
=================================

// Module: race_sequencer
// PURPOSE
//  Top-level game-flow controller for the two-car racer. Drives the shared 3-bit state bus into both
//  physics engines, runs the start countdown, times the race in centiseconds, handles pause/abort,
//  and resolves the winner from the two per-car finish flags. Sits between the debounced buttons and
//  the physics engines / HUD.
// PARAMETERS
//  CLK_FREQ         100_000_000  clk cycles per second (must be a multiple of 100)
//  COUNT_SECS       3            countdown length in seconds (1..15)
//  FINISH_HOLD_SECS 5            seconds FINISH is held before auto-return to IDLE (1..15)
//  TIME_MAX         9999         race timer saturation value, centiseconds
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  start_pulse  in   1   1-cycle debounced start button
//  cfg_done     in   1   1-cycle pulse: car/colour setup finished
//  pause_pulse  in   1   1-cycle debounced pause toggle
//  abort        in   1   1-cycle pulse: return to IDLE from any state
//  p1_finish    in   1   level, car 1 physics engine finish flag
//  p2_finish    in   1   level, car 2 physics engine finish flag
//  state        out  3   game state bus to both physics engines
//  countdown    out  4   seconds remaining in COUNTDOWN, else 0
//  winner       out  2   0 none, 1 car1, 2 car2, 3 tie
//  race_cs      out  14  elapsed race time, centiseconds
//  race_start   out  1   1-cycle pulse on COUNTDOWN->RACING
// BEHAVIOUR
//  - Reset: state=IDLE(0), countdown=0, winner=0, race_cs=0, race_start=0, all internal counters 0.
//  - Encoding: IDLE=0 SETTING=1 COUNTDOWN=3 RACING=4 PAUSE=5 FINISH=6; codes 2,7 illegal -> IDLE next cycle.
//  - All outputs registered; state changes one cycle after the causing input.
//  - Priority each cycle: rst > abort (non-IDLE) > finish detect > pause_pulse > start/cfg/timers.
//  - IDLE: start_pulse -> SETTING; on that transition winner<=0. race_cs/winner otherwise hold (HUD shows last result).
//  - SETTING: cfg_done -> COUNTDOWN; countdown<=COUNT_SECS, sec_cnt<=0.
//  - COUNTDOWN: sec_cnt counts 0..CLK_FREQ-1; at wrap countdown decrements; wrap with countdown==1 ->
//    RACING, countdown<=0, race_cs<=0, cs_cnt<=0, race_start=1 for one cycle. COUNTDOWN lasts exactly
//    COUNT_SECS*CLK_FREQ cycles. pause_pulse ignored.
//  - RACING: cs_cnt counts 0..CLK_FREQ/100-1; at wrap race_cs+=1, saturating at TIME_MAX (no wrap).
//    p1_finish/p2_finish sampled every cycle: either set -> FINISH; winner = 1 if only p1, 2 if only p2,
//    3 if both in same cycle. Finish beats pause_pulse in the same cycle. pause_pulse -> PAUSE.
//  - PAUSE: race_cs and cs_cnt frozen (resume continues mid-centisecond); pause_pulse -> RACING;
//    finish flags ignored in PAUSE.
//  - FINISH: race_cs and winner frozen; sec_cnt/hold_cnt run; after FINISH_HOLD_SECS*CLK_FREQ cycles
//    -> IDLE; start_pulse -> IDLE immediately (next cycle).
//  - abort in any non-IDLE state -> IDLE next cycle, countdown<=0, counters cleared, winner/race_cs hold.
//  - Finish flags are levels owned by the physics engines (cleared by them in IDLE); no edge detect needed.
// TESTING (CLK_FREQ=1000, COUNT_SECS=3, FINISH_HOLD_SECS=2)
//  1 rst high 2 cycles -> state=0, countdown=0, winner=0, race_cs=0; start_pulse -> state=1 next cycle.
//  2 cfg_done in SETTING -> state=3, countdown=3; 2=after 1000 cyc, 1=after 2000; state=4 + race_start
//    exactly 3000 cycles after entry, race_cs=0.
//  3 RACING 500 cycles -> race_cs=50; pause_pulse -> state=5, 300 idle cycles race_cs stays 50;
//    pause_pulse -> state=4, +100 cycles -> race_cs=60.
//  4 p2_finish and pause_pulse same cycle -> state=6, winner=2; p1&p2 same cycle (new race) -> winner=3;
//    FINISH auto-returns to state=0 after 2000 cycles, race_cs/winner held.
//  5 abort in COUNTDOWN (countdown=2) -> state=0, countdown=0; force internal state=2 -> state=0 next cycle.
//  6 RACING with CLK_FREQ/100 ticks beyond 9999 -> race_cs stays 9999; rst mid-RACING -> all outputs reset values.

Source files
------------

// File: rtl/race_sequencer.sv
// Game-flow controller for the two-car racer: drives the shared state bus, runs the start
// countdown, times the race in centiseconds, handles pause/abort and resolves the winner.
module race_sequencer #(
  parameter int unsigned CLK_FREQ         = 100_000_000,
  parameter int unsigned COUNT_SECS       = 3,
  parameter int unsigned FINISH_HOLD_SECS = 5,
  parameter int unsigned TIME_MAX         = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_pulse,
  input  logic        cfg_done,
  input  logic        pause_pulse,
  input  logic        abort,
  input  logic        p1_finish,
  input  logic        p2_finish,
  output logic [2:0]  state,
  output logic [3:0]  countdown,
  output logic [1:0]  winner,
  output logic [13:0] race_cs,
  output logic        race_start
);

  localparam int unsigned CS_DIV = CLK_FREQ / 100;
  localparam int unsigned SEC_W  = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int unsigned CS_W   = (CS_DIV > 1) ? $clog2(CS_DIV) : 1;

  localparam logic [SEC_W-1:0] SEC_LAST  = SEC_W'(CLK_FREQ - 1);
  localparam logic [CS_W-1:0]  CS_LAST   = CS_W'(CS_DIV - 1);
  localparam logic [3:0]       CD_INIT   = 4'(COUNT_SECS);
  localparam logic [3:0]       HOLD_LAST = 4'(FINISH_HOLD_SECS - 1);
  localparam logic [13:0]      CS_MAX    = 14'(TIME_MAX);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETTING   = 3'd1,
    S_COUNTDOWN = 3'd3,
    S_RACING    = 3'd4,
    S_PAUSE     = 3'd5,
    S_FINISH    = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        countdown_q, countdown_d;
  logic [1:0]        winner_q, winner_d;
  logic [13:0]       race_cs_q, race_cs_d;
  logic              race_start_q, race_start_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [CS_W-1:0]   cs_q, cs_d;
  logic [3:0]        hold_q, hold_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      countdown_q  <= '0;
      winner_q     <= '0;
      race_cs_q    <= '0;
      race_start_q <= 1'b0;
      sec_q        <= '0;
      cs_q         <= '0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      countdown_q  <= countdown_d;
      winner_q     <= winner_d;
      race_cs_q    <= race_cs_d;
      race_start_q <= race_start_d;
      sec_q        <= sec_d;
      cs_q         <= cs_d;
      hold_q       <= hold_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    countdown_d  = countdown_q;
    winner_d     = winner_q;
    race_cs_d    = race_cs_q;
    race_start_d = 1'b0;
    sec_d        = sec_q;
    cs_d         = cs_q;
    hold_d       = hold_q;

    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      countdown_d = '0;
      sec_d       = '0;
      cs_d        = '0;
      hold_d      = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_pulse) begin
            state_d  = S_SETTING;
            winner_d = '0;
          end
        end
        S_SETTING: begin
          if (cfg_done) begin
            state_d     = S_COUNTDOWN;
            countdown_d = CD_INIT;
            sec_d       = '0;
          end
        end
        S_COUNTDOWN: begin
          if (sec_q == SEC_LAST) begin
            sec_d = '0;
            if (countdown_q == 4'd1) begin
              state_d      = S_RACING;
              countdown_d  = '0;
              race_cs_d    = '0;
              cs_d         = '0;
              race_start_d = 1'b1;
            end else begin
              countdown_d = countdown_q - 4'd1;
            end
          end else begin
            sec_d = sec_q + SEC_W'(1);
          end
        end
        S_RACING: begin
          // Finish outranks pause; winner code is simply {p2, p1}.
          if (p1_finish || p2_finish) begin
            state_d  = S_FINISH;
            winner_d = {p2_finish, p1_finish};
            sec_d    = '0;
            hold_d   = '0;
          end else if (pause_pulse) begin
            state_d = S_PAUSE;
          end else if (cs_q == CS_LAST) begin
            cs_d = '0;
            if (race_cs_q < CS_MAX)
              race_cs_d = race_cs_q + 14'd1;
          end else begin
            cs_d = cs_q + CS_W'(1);
          end
        end
        S_PAUSE: begin
          if (pause_pulse)
            state_d = S_RACING;
        end
        S_FINISH: begin
          if (start_pulse) begin
            state_d = S_IDLE;
            sec_d   = '0;
            hold_d  = '0;
          end else if (sec_q == SEC_LAST) begin
            sec_d = '0;
            if (hold_q == HOLD_LAST) begin
              state_d = S_IDLE;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + 4'd1;
            end
          end else begin
            sec_d = sec_q + SEC_W'(1);
          end
        end
        default: begin
          state_d     = S_IDLE;
          countdown_d = '0;
          sec_d       = '0;
          cs_d        = '0;
          hold_d      = '0;
        end
      endcase
    end
  end

  assign state      = state_q;
  assign countdown  = countdown_q;
  assign winner     = winner_q;
  assign race_cs    = race_cs_q;
  assign race_start = race_start_q;

endmodule

// File: tb/tb_race_sequencer.sv
// Bench for race_sequencer: directed scenarios plus random play, every cycle compared
// against a reference built from elapsed-cycle and effective-tick counts.
module tb_race_sequencer;

  localparam int unsigned CLK_FREQ = 1000;
  localparam int unsigned CSECS    = 3;
  localparam int unsigned HOLD     = 2;
  localparam int unsigned TMAX     = 150;
  localparam int unsigned DIV      = CLK_FREQ / 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_pulse = 1'b0, cfg_done = 1'b0, pause_pulse = 1'b0, abort = 1'b0;
  logic        p1_finish = 1'b0, p2_finish = 1'b0;
  logic [2:0]  state;
  logic [3:0]  countdown;
  logic [1:0]  winner;
  logic [13:0] race_cs;
  logic        race_start;

  int checks = 0;
  int errors = 0;

  // Reference: state code, countdown, winner, cycles spent in current timed phase,
  // and total effective racing cycles since race start.
  int m_state = 0, m_cd = 0, m_win = 0, m_elapsed = 0, m_ticks = 0;
  bit m_rs = 1'b0;

  race_sequencer #(
    .CLK_FREQ(CLK_FREQ),
    .COUNT_SECS(CSECS),
    .FINISH_HOLD_SECS(HOLD),
    .TIME_MAX(TMAX)
  ) dut (
    .clk(clk), .rst(rst), .start_pulse(start_pulse), .cfg_done(cfg_done),
    .pause_pulse(pause_pulse), .abort(abort), .p1_finish(p1_finish), .p2_finish(p2_finish),
    .state(state), .countdown(countdown), .winner(winner), .race_cs(race_cs),
    .race_start(race_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_cs();
    int c;
    c = m_ticks / DIV;
    return (c > TMAX) ? TMAX : c;
  endfunction

  task automatic model_update();
    m_rs = 1'b0;
    if (rst) begin
      m_state = 0; m_cd = 0; m_win = 0; m_elapsed = 0; m_ticks = 0;
    end else if (m_state != 0 && abort) begin
      m_state = 0; m_cd = 0;
    end else begin
      case (m_state)
        0: if (start_pulse) begin m_state = 1; m_win = 0; end
        1: if (cfg_done) begin m_state = 3; m_cd = CSECS; m_elapsed = 0; end
        3: begin
          m_elapsed++;
          if (m_elapsed == CSECS * CLK_FREQ) begin
            m_state = 4; m_cd = 0; m_ticks = 0; m_rs = 1'b1;
          end else begin
            m_cd = CSECS - m_elapsed / CLK_FREQ;
          end
        end
        4: begin
          if (p1_finish || p2_finish) begin
            m_state = 6; m_elapsed = 0;
            m_win = (p1_finish && p2_finish) ? 3 : (p1_finish ? 1 : 2);
          end else if (pause_pulse) begin
            m_state = 5;
          end else begin
            m_ticks++;
          end
        end
        5: if (pause_pulse) m_state = 4;
        6: begin
          m_elapsed++;
          if (start_pulse || m_elapsed == HOLD * CLK_FREQ) m_state = 0;
        end
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic step(input bit sp, input bit cd, input bit pp, input bit ab);
    logic [23:0] exp_v;
    int cs;
    start_pulse = sp; cfg_done = cd; pause_pulse = pp; abort = ab;
    @(posedge clk);
    model_update();
    #1;
    start_pulse = 1'b0; cfg_done = 1'b0; pause_pulse = 1'b0; abort = 1'b0;
    cs = model_cs();
    exp_v = {m_state[2:0], m_cd[3:0], m_win[1:0], cs[13:0], m_rs};
    check("cycle", {8'h0, state, countdown, winner, race_cs, race_start}, {8'h0, exp_v});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset and entry to SETTING
    rst = 1'b1;
    run(2);
    check("rst_state", state, 0);
    check("rst_countdown", countdown, 0);
    check("rst_winner", winner, 0);
    check("rst_race_cs", race_cs, 0);
    rst = 1'b0;
    step(1, 0, 0, 0);
    check("idle_to_setting", state, 1);

    // Countdown timing
    step(0, 1, 0, 0);
    check("cd_state", state, 3);
    check("cd_init", countdown, 3);
    run(1000);
    check("cd_two", countdown, 2);
    run(1000);
    check("cd_one", countdown, 1);
    run(999);
    check("cd_last_cycle", state, 3);
    run(1);
    check("racing_state", state, 4);
    check("race_start_pulse", race_start, 1);
    check("race_cs_zero", race_cs, 0);

    // Timing and pause
    run(500);
    check("race_cs_50", race_cs, 50);
    step(0, 0, 1, 0);
    check("paused", state, 5);
    run(300);
    check("pause_frozen", race_cs, 50);
    step(0, 0, 1, 0);
    check("resumed", state, 4);
    run(100);
    check("race_cs_60", race_cs, 60);

    // p2 finish beats pause; auto-return from FINISH
    p2_finish = 1'b1;
    step(0, 0, 1, 0);
    check("finish_state", state, 6);
    check("winner_p2", winner, 2);
    run(1999);
    check("finish_hold", state, 6);
    run(1);
    check("finish_auto_idle", state, 0);
    check("winner_held", winner, 2);
    check("race_cs_held", race_cs, 60);
    p2_finish = 1'b0;

    // Tie, then start_pulse leaves FINISH early
    step(1, 0, 0, 0);
    check("winner_cleared", winner, 0);
    step(0, 1, 0, 0);
    run(3037);
    p1_finish = 1'b1; p2_finish = 1'b1;
    step(0, 0, 0, 0);
    check("winner_tie", winner, 3);
    p1_finish = 1'b0; p2_finish = 1'b0;
    step(1, 0, 0, 0);
    check("finish_start_idle", state, 0);
    check("tie_held", winner, 3);

    // Abort during countdown
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    run(1000);
    check("abort_pre_cd", countdown, 2);
    step(0, 0, 0, 1);
    check("abort_state", state, 0);
    check("abort_countdown", countdown, 0);

    // Saturation and reset mid-race
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    run(3000);
    run(TMAX * DIV + 40);
    check("race_cs_saturated", race_cs, TMAX);
    rst = 1'b1;
    step(0, 0, 0, 0);
    check("midrace_rst", {state, countdown, winner, race_cs, race_start}, 0);
    rst = 1'b0;

    // Random play against the reference
    for (int i = 0; i < 30000; i++) begin
      bit sp, cd, pp, ab;
      sp = ($urandom_range(0, 299) == 0);
      cd = ($urandom_range(0, 49) == 0);
      pp = ($urandom_range(0, 399) == 0);
      ab = ($urandom_range(0, 4999) == 0);
      rst = ($urandom_range(0, 14999) == 0);
      if (m_state == 0) begin
        p1_finish = 1'b0; p2_finish = 1'b0;
      end else if (m_state == 4) begin
        if ($urandom_range(0, 1499) == 0) p1_finish = 1'b1;
        if ($urandom_range(0, 1499) == 0) p2_finish = 1'b1;
      end
      step(sp, cd, pp, ab);
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
